irq_pending_gen: RTL and testbench
==================================

Name: irq_pending_gen

Overview:
Machine-level interrupt source block that builds the `mip` word consumed by the CSR interrupt controller. It contains:
- a 64-bit `mtime` counter with prescaler;
- a 64-bit `mtimecmp` register;
- a software-interrupt (`msip`) register;
- 2-flop synchronisers for the asynchronous external and local interrupt lines, each local line configurable as level- or edge-triggered.

Registers are accessed through a simple word-addressed memory-mapped port on the SoC peripheral bus.

Parameters:
- `PRESCALE`, 1, clk cycles per `mtime` increment; legal range 1..65535.
- `NUM_LOCAL`, 4, number of platform local interrupt lines; legal range 0..16; line i maps to `mip[16+i]`.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `wr_en`  in  1  register write strobe, single cycle
- `rd_en`  in  1  register read strobe, single cycle
- `addr`  in  5  byte address; `addr[4:2]` selects the word; `addr[1:0]` ignored
- `wdata`  in  32  write data
- `rdata`  out  32  read data, registered
- `rvalid`  out  1  one-cycle pulse, `rdata` valid
- `meip_in`  in  1  asynchronous external interrupt, level
- `local_irq`  in  `NUM_LOCAL`  asynchronous local interrupt lines
- `mip`  out  32  machine interrupt-pending word

Behaviour:
Clocking and reset:
- One clock domain.
- Reset is synchronous and active-high, named `reset`.
- Reset values: `mtime`=0, prescale count=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, `local_mode`=0 (all level), edge latches=0, all sync flops=0, `rdata`=0, `rvalid`=0, `mip`=0.
- Reset asserted mid-operation overrides all writes and increments in that cycle.

Register map (`addr[4:2]`):
- 0: `msip` (bit0; other bits read 0)
- 1: `mtimecmp[31:0]`
- 2: `mtimecmp[63:32]`
- 3: `mtime[31:0]`
- 4: `mtime[63:32]`
- 5: `local_mode[NUM_LOCAL-1:0]` (1=edge)
- 6: edge-pending, W1C; reads the edge latches
- 7: unmapped; reads 0, writes ignored

Read port:
- `rd_en` at cycle N -> `rdata`/`rvalid` at cycle N+1.
- `rvalid` is 0 otherwise; `rdata` holds its last value.
- Simultaneous `wr_en`+`rd_en` to the same word: the read returns the pre-write value.
- 64-bit reads are not atomic; software uses a hi-lo-hi read sequence.

Timer:
- Prescale counter counts 0..PRESCALE-1, wraps to 0; `tick` asserts on the wrap cycle.
- `PRESCALE`=1 gives `tick` every cycle.
- On `tick`, `mtime` += 1 modulo 2^64; all-ones wraps to 0.
- A write to either `mtime` half loads that half; the other half holds; the increment is suppressed that cycle. The prescale counter is unaffected.
- `mtip` is a register updated every cycle with unsigned (`mtime` >= `mtimecmp`), using current register values. Latency is 1 cycle after the compare condition changes.
- Writing `mtimecmp` above `mtime` clears `mtip` on the following cycle.

Synchronisers and local lines:
- `meip_in` and each `local_irq[i]` pass through 2 flops (s1, s2); a third flop s3 is used for edge detection.
- Edge latch i sets when s2 & ~s3 (rising edge).
- Edge latch i clears on a W1C write to word 6 with `wdata[i]`=1.
- Set and clear in the same cycle: set wins.
- Edge latches update regardless of mode.

`mip` composition (registered, updated every cycle):
- bit3 = `msip`
- bit7 = `mtip`
- bit11 = `meip` s2
- bit(16+i) = `local_mode[i]` ? latch[i] : s2[i]
- all other bits 0

Latency:
- Async input to `mip`: 3 cycles (2 sync + `mip` register).
- `msip` write to `mip[3]`: 1 cycle.

Test Plan:
1. Reset, then read words 0..7 -> `msip`=0, `mtimecmp`=all ones, `mtime`=0 (+ elapsed ticks), `mode`=0, `pending`=0, word7=0; `mip`=0; `rvalid` 1 cycle after each `rd_en`.
2. `PRESCALE`=4: write `mtimecmp`={0,10} -> `mtime` increments every 4th cycle; `mip[7]` rises 1 cycle after `mtime` reaches 10 (cycle ~41 after reset release); writing `mtimecmp_lo`=100 drops `mip[7]` 1 cycle later.
3. Write `mtime`={0,FFFF_FFFF} then `mtime_hi`=FFFF_FFFF and let it tick -> `mtime` wraps to 0; `mip[7]` clears if `mtimecmp` > 0; no increment in the write cycle.
4. Local line 1 in level mode: assert `local_irq[1]` -> `mip[17]`=1 after 3 cycles; deassert -> 0 after 3 cycles.
5. Switch line 1 to edge mode (word5=2): pulse `local_irq[1]` for 2 cycles -> `mip[17]` stays 1 after the pulse. W1C word6=2 -> cleared next cycle. New rising edge in the same cycle as the W1C -> bit remains 1.
6. Write `msip`=1 with a simultaneous read of word0 -> `rdata`=0, `mip[3]`=1 next cycle. Assert `reset` mid-count -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/irq_pending_gen.sv
// Machine interrupt source block: prescaled mtime/mtimecmp timer, msip, and
// synchronised external/local interrupt lines merged into the mip word.
module irq_pending_gen #(
  parameter int PRESCALE  = 1,
  parameter int NUM_LOCAL = 4,
  localparam int LW       = (NUM_LOCAL > 0) ? NUM_LOCAL : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [4:0]    addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          rvalid,
  input  logic          meip_in,
  input  logic [LW-1:0] local_irq,
  output logic [31:0]   mip
);

  localparam logic [15:0]   PMAX  = 16'(PRESCALE - 1);
  localparam logic [LW-1:0] LMASK = (NUM_LOCAL > 0) ? {LW{1'b1}} : {LW{1'b0}};

  logic [15:0]   pcount;
  logic          tick;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          msip;
  logic          msip_nxt;
  logic [LW-1:0] local_mode;
  logic [LW-1:0] edge_pend;
  logic [LW-1:0] edge_nxt;
  logic [LW-1:0] loc_s1, loc_s2, loc_s3;
  logic          meip_s1, meip_s2;
  logic [2:0]    widx;
  logic [31:0]   rd_word;
  logic [31:0]   mip_nxt;
  logic          unused_addr;

  assign widx        = addr[4:2];
  assign unused_addr = ^addr[1:0];
  assign tick        = (pcount == PMAX);

  always_comb begin
    msip_nxt = msip;
    if (wr_en && widx == 3'd0)
      msip_nxt = wdata[0];
  end

  // W1C clear first, then OR in new rising edges so a simultaneous set wins
  always_comb begin
    edge_nxt = edge_pend;
    if (wr_en && widx == 3'd6)
      edge_nxt = edge_pend & ~wdata[LW-1:0];
    edge_nxt = edge_nxt | (loc_s2 & ~loc_s3 & LMASK);
  end

  // Next-state values feed mip so msip and edge-clear show up one cycle after the write
  always_comb begin
    mip_nxt     = '0;
    mip_nxt[3]  = msip_nxt;
    mip_nxt[7]  = (mtime >= mtimecmp);
    mip_nxt[11] = meip_s2;
    for (int i = 0; i < NUM_LOCAL; i++)
      mip_nxt[16+i] = local_mode[i] ? edge_nxt[i] : loc_s2[i];
  end

  always_comb begin
    rd_word = '0;
    case (widx)
      3'd0:    rd_word = {31'b0, msip};
      3'd1:    rd_word = mtimecmp[31:0];
      3'd2:    rd_word = mtimecmp[63:32];
      3'd3:    rd_word = mtime[31:0];
      3'd4:    rd_word = mtime[63:32];
      3'd5:    rd_word = 32'(local_mode);
      3'd6:    rd_word = 32'(edge_pend);
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcount     <= '0;
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      local_mode <= '0;
      edge_pend  <= '0;
      loc_s1     <= '0;
      loc_s2     <= '0;
      loc_s3     <= '0;
      meip_s1    <= 1'b0;
      meip_s2    <= 1'b0;
      mip        <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
    end else begin
      pcount <= tick ? '0 : pcount + 16'd1;
      // A write to either half of mtime takes priority over the tick increment
      if (wr_en && widx == 3'd3)
        mtime[31:0] <= wdata;
      else if (wr_en && widx == 3'd4)
        mtime[63:32] <= wdata;
      else if (tick)
        mtime <= mtime + 64'd1;
      if (wr_en && widx == 3'd1)
        mtimecmp[31:0] <= wdata;
      if (wr_en && widx == 3'd2)
        mtimecmp[63:32] <= wdata;
      if (wr_en && widx == 3'd5)
        local_mode <= wdata[LW-1:0] & LMASK;
      msip      <= msip_nxt;
      edge_pend <= edge_nxt;
      loc_s1    <= local_irq & LMASK;
      loc_s2    <= loc_s1;
      loc_s3    <= loc_s2;
      meip_s1   <= meip_in;
      meip_s2   <= meip_s1;
      mip       <= mip_nxt;
      rvalid    <= rd_en;
      if (rd_en)
        rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_irq_pending_gen.sv
// Directed testbench for irq_pending_gen with PRESCALE=4 and four local lines.
module tb_irq_pending_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        meip_in = 1'b0;
  logic [3:0]  local_irq = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] mip;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  irq_pending_gen #(.PRESCALE(4), .NUM_LOCAL(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .meip_in(meip_in),
    .local_irq(local_irq), .mip(mip)
  );

  always #5 clk = ~clk;

  // Edges since reset release; mtime model is cyc/4 while mtime is not written
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] w, input logic [31:0] d);
    wr_en = 1'b1; addr = {w, 2'b00}; wdata = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] w, output logic [31:0] d, output logic v);
    rd_en = 1'b1; addr = {w, 2'b10};
    step();
    rd_en = 1'b0;
    d = rdata; v = rvalid;
  endtask

  task automatic test_reset();
    logic [31:0] exp_w [8];
    logic [31:0] d;
    logic v;
    exp_w = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (mip !== 32'h0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got mip=%h rvalid=%b rdata=%h expected 0/0/0", mip, rvalid, rdata);
    end
    reset = 1'b0;
    for (int w = 0; w < 8; w++) begin
      do_read(3'(w), d, v);
      checks++;
      if (d !== exp_w[w] || v !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_word%0d: got %h rvalid=%b expected %h rvalid=1", w, d, v, exp_w[w]);
      end
    end
    step();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rvalid_pulse: got %b expected 0", rvalid);
    end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    logic v;
    logic found;
    int exp_t;
    do_write(3'd2, 32'h0);
    do_write(3'd1, 32'd10);
    checks++;
    if (mip[7] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mtip_early: got %b expected 0", mip[7]);
    end
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mip[7] === 1'b1) found = 1'b1;
      else step();
    end
    checks++;
    if (!found || cyc != 41) begin
      errors++;
      $display("[TB] FAIL mtip_rise_cycle: got found=%b cycle=%0d expected found=1 cycle=41", found, cyc);
    end
    exp_t = cyc / 4;
    do_read(3'd3, d, v);
    checks++;
    if (d !== 32'(exp_t)) begin
      errors++;
      $display("[TB] FAIL mtime_lo_count: got %0d expected %0d", d, exp_t);
    end
    do_write(3'd1, 32'd100);
    checks++;
    if (mip[7] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mtip_hold_on_write: got %b expected 1", mip[7]);
    end
    step();
    checks++;
    if (mip[7] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mtip_clear: got %b expected 0", mip[7]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic v;
    for (int i = 0; i < 8 && (cyc % 4) != 2; i++) step();
    do_write(3'd3, 32'hFFFF_FFFF);
    do_write(3'd4, 32'hFFFF_FFFF);
    checks++;
    if (mip[7] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_mtip_set: got %b expected 1", mip[7]);
    end
    do_read(3'd3, d, v);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL wrap_no_inc_lo: got %h expected ffffffff", d);
    end
    do_read(3'd4, d, v);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL wrap_no_inc_hi: got %h expected ffffffff", d);
    end
    step();
    step();
    checks++;
    if (mip[7] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_mtip_before: got %b expected 1", mip[7]);
    end
    step();
    checks++;
    if (mip[7] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_mtip_after: got %b expected 0", mip[7]);
    end
    do_read(3'd3, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_lo_zero: got %h expected 0", d);
    end
    do_read(3'd4, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_hi_zero: got %h expected 0", d);
    end
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic v;
    local_irq[1] = 1'b1;
    step(); step();
    checks++;
    if (mip[17] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL level_rise_early: got %b expected 0", mip[17]);
    end
    step();
    checks++;
    if (mip[17] !== 1'b1 || mip[16] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL level_rise: got mip[17:16]=%b expected 10", mip[17:16]);
    end
    local_irq[1] = 1'b0;
    step(); step();
    checks++;
    if (mip[17] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL level_fall_early: got %b expected 1", mip[17]);
    end
    step();
    checks++;
    if (mip[17] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL level_fall: got %b expected 0", mip[17]);
    end
    do_read(3'd6, d, v);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("[TB] FAIL latch_in_level_mode: got %h expected 2", d);
    end
    meip_in = 1'b1;
    step(); step();
    checks++;
    if (mip[11] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL meip_early: got %b expected 0", mip[11]);
    end
    step();
    checks++;
    if (mip[11] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL meip_rise: got %b expected 1", mip[11]);
    end
    meip_in = 1'b0;
    repeat (3) step();
    checks++;
    if (mip[11] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL meip_fall: got %b expected 0", mip[11]);
    end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    logic v;
    do_write(3'd5, 32'h2);
    do_write(3'd6, 32'hF);
    checks++;
    if (mip[17] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge_cleared_start: got %b expected 0", mip[17]);
    end
    do_read(3'd5, d, v);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("[TB] FAIL mode_readback: got %h expected 2", d);
    end
    local_irq[1] = 1'b1;
    step(); step();
    local_irq[1] = 1'b0;
    step();
    checks++;
    if (mip[17] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_set: got %b expected 1", mip[17]);
    end
    repeat (5) step();
    checks++;
    if (mip[17] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_sticky: got %b expected 1", mip[17]);
    end
    do_read(3'd6, d, v);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("[TB] FAIL edge_pending_read: got %h expected 2", d);
    end
    do_write(3'd6, 32'h2);
    checks++;
    if (mip[17] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge_w1c: got %b expected 0", mip[17]);
    end
    local_irq[1] = 1'b1;
    step(); step();
    do_write(3'd6, 32'h2);
    checks++;
    if (mip[17] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_set_wins: got %b expected 1", mip[17]);
    end
    local_irq[1] = 1'b0;
    do_read(3'd6, d, v);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("[TB] FAIL edge_set_wins_read: got %h expected 2", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic v;
    wr_en = 1'b1; rd_en = 1'b1; addr = 5'd0; wdata = 32'h1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (rdata !== 32'h0 || rvalid !== 1'b1 || mip[3] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL msip_rw_same: got rdata=%h rvalid=%b mip3=%b expected 0/1/1", rdata, rvalid, mip[3]);
    end
    do_read(3'd0, d, v);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("[TB] FAIL msip_readback: got %h expected 1", d);
    end
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addr = {3'd1, 2'b00}; wdata = 32'h5;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (mip !== 32'h0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got mip=%h rvalid=%b rdata=%h expected 0/0/0", mip, rvalid, rdata);
    end
    reset = 1'b0;
    do_read(3'd1, d, v);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL midreset_cmp: got %h expected ffffffff", d);
    end
    do_read(3'd0, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_msip: got %h expected 0", d);
    end
    do_read(3'd3, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_mtime: got %h expected 0", d);
    end
    do_read(3'd5, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_mode: got %h expected 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_wrap();
    test_level();
    test_edge();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
